// File: rtl/ahbl_excl_sram_pkg.sv
// Shared types and helpers for the exclusive-access SRAM responder.
package ahbl_excl_sram_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam int W_MASTER = 8;
    localparam int W_CNT    = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_t;

    // Byte-lane enables for a transfer of 2**size bytes starting at lane ofs.
    function automatic logic [7:0] size_to_mask(input logic [2:0] size, input logic [2:0] ofs);
        logic [7:0] base;
        case (size)
            3'd0:    base = 8'h01;
            3'd1:    base = 8'h03;
            3'd2:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << ofs;
    endfunction

    // Low address bits that must be zero for a naturally aligned transfer.
    function automatic logic [2:0] size_low_bits(input logic [2:0] size);
        case (size)
            3'd0:    return 3'b000;
            3'd1:    return 3'b001;
            3'd2:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/ahbl_excl_sram_if.sv
// AHB-Lite slave-port bundle with exclusive-access sideband.
interface ahbl_excl_sram_if #(
    parameter int W_ADDR = 32,
    parameter int W_DATA = 32
);
    logic              hready;
    logic              hready_resp;
    logic              hresp;
    logic [W_ADDR-1:0] haddr;
    logic              hwrite;
    logic [1:0]        htrans;
    logic [2:0]        hsize;
    logic [2:0]        hburst;
    logic [3:0]        hprot;
    logic              hmastlock;
    logic [W_DATA-1:0] hwdata;
    logic [W_DATA-1:0] hrdata;
    logic              hexcl;
    logic [7:0]        hmaster;
    logic              hexokay;

    modport slave (
        input  hready, haddr, hwrite, htrans, hsize, hburst, hprot, hmastlock,
               hwdata, hexcl, hmaster,
        output hready_resp, hresp, hrdata, hexokay
    );

    modport master (
        output hready, haddr, hwrite, htrans, hsize, hburst, hprot, hmastlock,
               hwdata, hexcl, hmaster,
        input  hready_resp, hresp, hrdata, hexokay
    );
endinterface

// File: rtl/ahbl_excl_monitor.sv
// Exclusive-access monitor: one {valid, word index} reservation per master.
module ahbl_excl_monitor
    import ahbl_excl_sram_pkg::*;
#(
    parameter int N_MASTERS = 4,
    parameter int W_IDX     = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [W_MASTER-1:0] master,
    input  logic [W_IDX-1:0]    idx,
    input  logic                set_en,
    input  logic                clr_self_en,
    input  logic                wr_en,
    output logic                match
);

    logic             valid [N_MASTERS];
    logic [W_IDX-1:0] resv  [N_MASTERS];

    // Does the current master hold a reservation on the current word?
    always_comb begin
        match = 1'b0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (valid[i] && (W_MASTER'(i) == master) && (resv[i] == idx))
                match = 1'b1;
        end
    end

    // Reservation update; a set on the own entry wins over any clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_MASTERS; i++) begin
                valid[i] <= 1'b0;
                resv[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < N_MASTERS; i++) begin
                if (wr_en && valid[i] && (resv[i] == idx) && (W_MASTER'(i) != master))
                    valid[i] <= 1'b0;
                if (clr_self_en && (W_MASTER'(i) == master))
                    valid[i] <= 1'b0;
                if (set_en && (W_MASTER'(i) == master)) begin
                    valid[i] <= 1'b1;
                    resv[i]  <= idx;
                end
            end
        end
    end

endmodule

// File: rtl/ahbl_excl_sram.sv
// AHB-Lite word SRAM responder with LR/SC-style exclusive monitor.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no data phase in progress, ready for an address phase
// ST_XFER | data phase of a good transfer; counts down wait states
// ST_ERR1 | first ERROR cycle (hready_resp low)
// ST_ERR2 | second ERROR cycle (hready_resp high)
module ahbl_excl_sram
    import ahbl_excl_sram_pkg::*;
#(
    parameter int W_ADDR      = 32,
    parameter int W_DATA      = 32,
    parameter int DEPTH       = 1024,
    parameter int N_MASTERS   = 4,
    parameter int WAIT_STATES = 0
) (
    input  logic clk,
    input  logic rst,
    ahbl_excl_sram_if.slave ahbls
);

    localparam int NB  = W_DATA / 8;
    localparam int OFS = $clog2(NB);
    localparam int IDX = $clog2(DEPTH);
    localparam bit ZERO_WAIT = (WAIT_STATES == 0);

    state_t             state, state_nxt;
    logic [W_CNT-1:0]   cnt, cnt_nxt;
    logic               rdy, err, done;
    logic               accept, bad, start_good;
    logic [IDX-1:0]     a_idx, l_idx, rd_idx;
    logic [7:0]         a_mask8;
    logic [NB-1:0]      l_mask;
    logic               l_write, l_excl;
    logic [W_MASTER-1:0] l_master;
    logic               mon_match, commit, rd_load;
    logic [W_DATA-1:0]  mem [DEPTH];
    logic [W_DATA-1:0]  rdata_q, rdata_nxt;
    logic               unused_bits;

    assign accept  = ahbls.hready & ahbls.htrans[1];
    assign a_idx   = ahbls.haddr[OFS +: IDX];
    assign a_mask8 = size_to_mask(ahbls.hsize, 3'(ahbls.haddr[OFS-1:0]));
    assign bad     = (ahbls.hsize > 3'(OFS))
                   | (|(ahbls.haddr[2:0] & size_low_bits(ahbls.hsize)))
                   | (ahbls.hexcl & ({1'b0, ahbls.hmaster} >= 9'(N_MASTERS)));
    assign start_good = rdy & accept & ~bad;

    assign unused_bits = ^{ahbls.hburst, ahbls.hprot, ahbls.hmastlock, ahbls.haddr};

    // State and wait-state counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state, counter and handshake outputs; a new accept overrides the fall-back.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rdy       = 1'b1;
        err       = 1'b0;
        done      = 1'b0;
        unique case (state)
            ST_XFER: begin
                if (cnt != '0) begin
                    rdy     = 1'b0;
                    cnt_nxt = cnt - 1'b1;
                end else begin
                    done      = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_ERR1: begin
                rdy       = 1'b0;
                err       = 1'b1;
                state_nxt = ST_ERR2;
            end
            ST_ERR2: begin
                err       = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (rdy && accept) begin
            if (bad) begin
                state_nxt = ST_ERR1;
                cnt_nxt   = '0;
            end else begin
                state_nxt = ST_XFER;
                cnt_nxt   = W_CNT'(WAIT_STATES);
            end
        end
    end

    // Address-phase capture for the data phase that follows.
    always_ff @(posedge clk) begin
        if (rst) begin
            l_idx    <= '0;
            l_mask   <= '0;
            l_write  <= 1'b0;
            l_excl   <= 1'b0;
            l_master <= '0;
        end else if (start_good) begin
            l_idx    <= a_idx;
            l_mask   <= a_mask8[NB-1:0];
            l_write  <= ahbls.hwrite;
            l_excl   <= ahbls.hexcl;
            l_master <= ahbls.hmaster;
        end
    end

    ahbl_excl_monitor #(
        .N_MASTERS (N_MASTERS),
        .W_IDX     (IDX)
    ) u_mon (
        .clk         (clk),
        .rst         (rst),
        .master      (l_master),
        .idx         (l_idx),
        .set_en      (done & l_excl & ~l_write),
        .clr_self_en (done & l_excl & l_write),
        .wr_en       (commit),
        .match       (mon_match)
    );

    // A failed exclusive write completes OKAY but leaves memory untouched.
    assign commit = done & l_write & (~l_excl | mon_match) & ~rst;

    assign ahbls.hready_resp = rdy;
    assign ahbls.hresp       = err;
    assign ahbls.hexokay     = done & l_excl & (~l_write | mon_match);
    assign ahbls.hrdata      = rdata_q;

    // Pick the word to load into the read register at the edge before a read completes.
    always_comb begin
        rd_load = 1'b0;
        rd_idx  = l_idx;
        if (ZERO_WAIT && start_good && !ahbls.hwrite) begin
            rd_load = 1'b1;
            rd_idx  = a_idx;
        end else if ((state == ST_XFER) && (cnt == W_CNT'(1)) && !l_write) begin
            rd_load = 1'b1;
        end
    end

    // Read data with byte forwarding from a write committing on the same edge.
    always_comb begin
        rdata_nxt = '0;
        if (rd_load) begin
            for (int b = 0; b < NB; b++) begin
                if (commit && (l_idx == rd_idx) && l_mask[b])
                    rdata_nxt[b*8 +: 8] = ahbls.hwdata[b*8 +: 8];
                else
                    rdata_nxt[b*8 +: 8] = mem[rd_idx][b*8 +: 8];
            end
        end
    end

    // Registered read data, zero whenever no read completes.
    always_ff @(posedge clk) begin
        if (rst) rdata_q <= '0;
        else     rdata_q <= rdata_nxt;
    end

    // Byte-lane write into the array; contents are not reset.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int b = 0; b < NB; b++) begin
                if (l_mask[b]) mem[l_idx][b*8 +: 8] <= ahbls.hwdata[b*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ahbl_excl_sram.sv
// Randomised bench for ahbl_excl_sram: a zero-wait and a two-wait instance share
// one stimulus driver; the driven instance is chosen by sel, the other sees IDLE.
module tb_ahbl_excl_sram;
    import ahbl_excl_sram_pkg::*;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
        logic        excl;
        logic [7:0]  master;
        logic [31:0] wdata;
    } xfer_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ahbl_excl_sram_if #(.W_ADDR(32), .W_DATA(32)) bus0();
    ahbl_excl_sram_if #(.W_ADDR(32), .W_DATA(32)) bus1();

    ahbl_excl_sram #(.WAIT_STATES(0)) dut0 (.clk(clk), .rst(rst), .ahbls(bus0));
    ahbl_excl_sram #(.WAIT_STATES(2)) dut1 (.clk(clk), .rst(rst), .ahbls(bus1));

    logic        sel = 1'b0;
    logic [31:0] t_haddr = '0, t_hwdata = '0;
    logic        t_hwrite = 1'b0, t_hexcl = 1'b0;
    logic [1:0]  t_htrans = HTRANS_IDLE;
    logic [2:0]  t_hsize = '0;
    logic [7:0]  t_hmaster = '0;

    assign bus0.hready = bus0.hready_resp;
    assign bus1.hready = bus1.hready_resp;
    assign bus0.htrans = sel ? HTRANS_IDLE : t_htrans;
    assign bus1.htrans = sel ? t_htrans : HTRANS_IDLE;
    assign bus0.haddr = t_haddr;    assign bus1.haddr = t_haddr;
    assign bus0.hwrite = t_hwrite;  assign bus1.hwrite = t_hwrite;
    assign bus0.hsize = t_hsize;    assign bus1.hsize = t_hsize;
    assign bus0.hwdata = t_hwdata;  assign bus1.hwdata = t_hwdata;
    assign bus0.hexcl = t_hexcl;    assign bus1.hexcl = t_hexcl;
    assign bus0.hmaster = t_hmaster; assign bus1.hmaster = t_hmaster;
    assign bus0.hburst = 3'b000;    assign bus1.hburst = 3'b000;
    assign bus0.hprot = 4'b0011;    assign bus1.hprot = 4'b0011;
    assign bus0.hmastlock = 1'b0;   assign bus1.hmastlock = 1'b0;

    logic        o_rdy, o_resp, o_exok;
    logic [31:0] o_rd;
    assign o_rdy  = sel ? bus1.hready_resp : bus0.hready_resp;
    assign o_resp = sel ? bus1.hresp : bus0.hresp;
    assign o_exok = sel ? bus1.hexokay : bus0.hexokay;
    assign o_rd   = sel ? bus1.hrdata : bus0.hrdata;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: word memory and per-master reservations, per instance.
    logic [31:0] mem_m [2][1024];
    bit          rv    [2][4];
    int          ri    [2][4];

    function automatic bit is_bad(input xfer_t x);
        return (x.size > 3'd2) || ((x.addr % (32'd1 << x.size)) != 0) ||
               (x.excl && (x.master >= 8'd4));
    endfunction

    task automatic model_complete(input xfer_t x, output logic [31:0] erd, output logic eok);
        int d   = sel ? 1 : 0;
        int idx = int'((x.addr >> 2) & 32'd1023);
        int m   = int'(x.master);
        logic [31:0] w;
        bit ok;
        erd = '0;
        eok = 1'b0;
        if (!x.write) begin
            erd = mem_m[d][idx];
            eok = x.excl;
            if (x.excl) begin
                rv[d][m] = 1'b1;
                ri[d][m] = idx;
            end
        end else begin
            ok  = !x.excl || (rv[d][m] && ri[d][m] == idx);
            eok = x.excl && ok;
            if (ok) begin
                w = mem_m[d][idx];
                for (int k = 0; k < (1 << x.size); k++) begin
                    int b = int'(x.addr % 4) + k;
                    w[b*8 +: 8] = x.wdata[b*8 +: 8];
                end
                mem_m[d][idx] = w;
                for (int mm = 0; mm < 4; mm++)
                    if (mm != m && rv[d][mm] && ri[d][mm] == idx) rv[d][mm] = 1'b0;
            end
            if (x.excl) rv[d][m] = 1'b0;
        end
    endtask

    xfer_t       q[$];
    xfer_t       dp, nx;
    bit          dp_valid = 0, nx_valid = 0, dp_bad = 0, gaps = 1;
    int          dp_waits = 0;
    logic [31:0] last_rd = '0;

    function automatic xfer_t mk(input logic [31:0] a, input logic wr, input logic [2:0] sz,
                                 input logic ex, input logic [7:0] m, input logic [31:0] wd);
        xfer_t x;
        x.addr = a; x.write = wr; x.size = sz; x.excl = ex; x.master = m; x.wdata = wd;
        return x;
    endfunction

    function automatic xfer_t rand_xfer();
        xfer_t x;
        int idx, off;
        x.size = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
        idx = $urandom_range(0, 5);
        if ($urandom_range(0, 7) == 0)  off = $urandom_range(0, 3);
        else if (x.size >= 3'd2)        off = 0;
        else                            off = ($urandom_range(0, 3) >> x.size) << x.size;
        x.addr   = ($urandom & 32'hFFFF_F000) | 32'(idx << 2) | 32'(off);
        x.write  = 1'($urandom_range(0, 1));
        x.excl   = ($urandom_range(0, 2) == 0);
        x.master = ($urandom_range(0, 9) == 0) ? 8'd4 : 8'($urandom_range(0, 3));
        x.wdata  = $urandom;
        return x;
    endfunction

    task automatic run_queue(input int max_cycles);
        int cyc = 0;
        int ws  = sel ? 2 : 0;
        logic [31:0] erd;
        logic        eok;
        while ((q.size() > 0 || dp_valid || nx_valid) && cyc < max_cycles) begin
            @(posedge clk); #1;
            if (nx_valid) begin
                dp = nx; dp_valid = 1; dp_waits = 0; dp_bad = is_bad(nx); nx_valid = 0;
            end
            t_hwdata = (dp_valid && dp.write) ? dp.wdata : $urandom;
            @(negedge clk);
            if (dp_valid) begin
                if (dp_bad) begin
                    if (dp_waits == 0) begin
                        chk("err1_rdy", 32'(o_rdy), 32'd0);
                        chk("err1_resp", 32'(o_resp), 32'd1);
                        chk("err1_exok", 32'(o_exok), 32'd0);
                        dp_waits++;
                    end else begin
                        chk("err2_rdy", 32'(o_rdy), 32'd1);
                        chk("err2_resp", 32'(o_resp), 32'd1);
                        chk("err2_exok", 32'(o_exok), 32'd0);
                        chk("err2_rdata", o_rd, 32'd0);
                        dp_valid = 0;
                    end
                end else if (!o_rdy) begin
                    chk("wait_resp", 32'(o_resp), 32'd0);
                    chk("wait_exok", 32'(o_exok), 32'd0);
                    chk("wait_rdata", o_rd, 32'd0);
                    dp_waits++;
                    if (dp_waits > 20) begin
                        chk("wait_bound", 32'(dp_waits), 32'(ws));
                        dp_valid = 0;
                    end
                end else begin
                    model_complete(dp, erd, eok);
                    chk("waits", 32'(dp_waits), 32'(ws));
                    chk("resp", 32'(o_resp), 32'd0);
                    chk("exokay", 32'(o_exok), 32'(eok));
                    chk("rdata", o_rd, erd);
                    if (!dp.write) last_rd = o_rd;
                    dp_valid = 0;
                end
            end else begin
                chk("idle_rdy", 32'(o_rdy), 32'd1);
                chk("idle_resp", 32'(o_resp), 32'd0);
                chk("idle_exok", 32'(o_exok), 32'd0);
                chk("idle_rdata", o_rd, 32'd0);
            end
            if (o_rdy && q.size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
                nx = q.pop_front();
                t_haddr = nx.addr; t_hwrite = nx.write; t_hsize = nx.size;
                t_hexcl = nx.excl; t_hmaster = nx.master;
                t_htrans = $urandom_range(0, 1) ? HTRANS_NONSEQ : HTRANS_SEQ;
                nx_valid = 1;
            end else begin
                t_htrans = $urandom_range(0, 1) ? HTRANS_IDLE : HTRANS_BUSY;
                t_haddr = $urandom; t_hwrite = 1'($urandom_range(0, 1));
                t_hsize = 3'($urandom_range(0, 7)); t_hexcl = 1'($urandom_range(0, 1));
            end
            cyc++;
        end
        chk("drained", 32'(q.size()) + 32'(dp_valid) + 32'(nx_valid), 32'd0);
    endtask

    initial begin
        int init_idx [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 16, 32};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rdy0", 32'(bus0.hready_resp), 32'd1);
        chk("rst_resp0", 32'(bus0.hresp), 32'd0);
        chk("rst_exok0", 32'(bus0.hexokay), 32'd0);
        chk("rst_rdata0", bus0.hrdata, 32'd0);
        chk("rst_rdy1", 32'(bus1.hready_resp), 32'd1);
        chk("rst_rdata1", bus1.hrdata, 32'd0);
        rst = 1'b0;

        for (int d = 0; d < 2; d++) begin
            sel = (d == 1);
            foreach (init_idx[i]) q.push_back(mk(32'(init_idx[i] * 4), 1, 3'd2, 0, 8'd0, $urandom));
            run_queue(400);
        end

        // Zero-wait instance: directed scenarios, back-to-back.
        sel = 0; gaps = 0;
        q.push_back(mk(32'h10, 1, 3'd2, 0, 8'd0, 32'hDEADBEEF));
        q.push_back(mk(32'h10, 0, 3'd2, 0, 8'd0, 32'h0));
        run_queue(50);
        chk("t1_fwd", last_rd, 32'hDEADBEEF);

        q.push_back(mk(32'h40, 0, 3'd2, 1, 8'd3, 32'h0));
        q.push_back(mk(32'h40, 1, 3'd2, 1, 8'd3, 32'h5));
        q.push_back(mk(32'h40, 0, 3'd2, 0, 8'd0, 32'h0));
        run_queue(50);
        chk("t2_read", last_rd, 32'h5);

        q.push_back(mk(32'h40, 0, 3'd2, 1, 8'd3, 32'h0));
        q.push_back(mk(32'h40, 1, 3'd2, 0, 8'd1, 32'h7));
        q.push_back(mk(32'h40, 1, 3'd2, 1, 8'd3, 32'h9));
        q.push_back(mk(32'h40, 0, 3'd2, 0, 8'd0, 32'h0));
        run_queue(50);
        chk("t3_read", last_rd, 32'h7);

        q.push_back(mk(32'h0, 1, 3'd2, 0, 8'd0, 32'h11223344));
        q.push_back(mk(32'h1, 1, 3'd1, 0, 8'd0, 32'hFFFFFFFF));
        q.push_back(mk(32'h0, 0, 3'd2, 0, 8'd0, 32'h0));
        run_queue(50);
        chk("t4_read", last_rd, 32'h11223344);

        gaps = 1;
        repeat (250) q.push_back(rand_xfer());
        run_queue(3000);

        // Two-wait instance.
        sel = 1;
        q.push_back(mk(32'h0, 0, 3'd2, 0, 8'd0, 32'h0));
        run_queue(50);
        repeat (120) q.push_back(rand_xfer());
        run_queue(3000);

        // Reset in the wait state of an exclusive write.
        q.push_back(mk(32'h80, 0, 3'd2, 1, 8'd2, 32'h0));
        run_queue(50);
        @(negedge clk);
        chk("t6_pre_rdy", 32'(bus1.hready_resp), 32'd1);
        t_haddr = 32'h80; t_hwrite = 1; t_hsize = 3'd2; t_hexcl = 1; t_hmaster = 8'd2;
        t_htrans = HTRANS_NONSEQ;
        @(posedge clk); #1;
        t_hwdata = 32'hCAFEF00D;
        t_htrans = HTRANS_IDLE;
        @(negedge clk);
        chk("t6_wait_rdy", 32'(bus1.hready_resp), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_rst_rdy", 32'(bus1.hready_resp), 32'd1);
        chk("t6_rst_resp", 32'(bus1.hresp), 32'd0);
        chk("t6_rst_exok", 32'(bus1.hexokay), 32'd0);
        chk("t6_rst_rdata", bus1.hrdata, 32'd0);
        for (int d = 0; d < 2; d++)
            for (int m = 0; m < 4; m++) rv[d][m] = 1'b0;
        q.push_back(mk(32'h80, 1, 3'd2, 1, 8'd2, 32'h12345678));
        q.push_back(mk(32'h80, 0, 3'd2, 0, 8'd0, 32'h0));
        run_queue(50);
        chk("t6_read", last_rd, mem_m[1][32]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
